// File: rtl/eth_encoder.sv
// Ethernet frame encoder: preamble/SFD, 14-byte header, payload pass-through, zero pad to 46 bytes, IFG.
// Latency: out_vld the cycle after ctrl accept; payload bytes pass combinationally from data_in to data_out.
// Backpressure: every byte waits for out_rdy; payload in_rdy follows out_rdy; the IFG counts only out_rdy cycles.
module eth_encoder #(
    parameter logic [47:0] P_MY_MAC    = 48'h00183E02523A,
    parameter int          P_IFG_BYTES = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] ctrl,
    input  logic        ctrl_vld,
    output logic        ctrl_rdy,
    input  logic [8:0]  data_in,
    input  logic        in_vld,
    output logic        in_rdy,
    output logic [8:0]  data_out,
    output logic        out_vld,
    input  logic        out_rdy,
    output logic        frame_done,
    output logic        len_err
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_PREAMBLE = 3'd1;
    localparam logic [2:0] S_HEADER   = 3'd2;
    localparam logic [2:0] S_PAYLOAD  = 3'd3;
    localparam logic [2:0] S_PAD      = 3'd4;
    localparam logic [2:0] S_IFG      = 3'd5;

    localparam logic [10:0] MAX_PAYLOAD = 11'd1500;
    localparam logic [10:0] MIN_PAYLOAD = 11'd46;
    localparam logic [10:0] CNT_SAT     = 11'd2047;
    localparam logic [10:0] PRE_LAST    = 11'd7;
    localparam logic [10:0] HDR_LAST    = 11'd13;
    localparam logic [10:0] PAD_LAST    = 11'd45;
    localparam logic [10:0] IFG_LAST    = 11'(P_IFG_BYTES - 1);

    typedef struct packed {
        logic [47:0] dst_mac;
        logic [47:0] src_mac;
        logic [15:0] ether_type;
    } hdr_t;

    logic [2:0]  state;
    // One counter serves every state: byte index in preamble/header,
    // accepted payload bytes, payload+pad total in PAD, gap slots in IFG.
    logic [10:0] cnt;
    logic [47:0] dst_q;
    logic [15:0] etype_q;
    logic        rdy_q;

    hdr_t        hdr;
    logic [6:0]  hdr_lsb;
    logic [7:0]  hdr_byte;
    logic        ctrl_acc;
    logic        in_acc;
    logic        out_xfer;
    logic        discard;
    logic        in_last;
    logic [10:0] pay_cnt_nxt;

    // Header bytes go out most-significant first, so byte n sits at bit 104-8n.
    always_comb begin
        hdr.dst_mac    = dst_q;
        hdr.src_mac    = P_MY_MAC;
        hdr.ether_type = etype_q;
        hdr_lsb        = 7'd104 - {cnt[3:0], 3'b000};
        hdr_byte       = hdr[hdr_lsb +: 8];
    end

    assign ctrl_rdy    = rdy_q && (state == S_IDLE);
    assign ctrl_acc    = ctrl_vld && ctrl_rdy;
    assign in_acc      = in_vld && in_rdy;
    assign out_xfer    = out_vld && out_rdy;
    assign in_last     = data_in[8];
    // Bytes past the 1500th are swallowed: accepted upstream, never emitted.
    assign discard     = (state == S_PAYLOAD) && (cnt >= MAX_PAYLOAD);
    assign pay_cnt_nxt = (cnt == CNT_SAT) ? cnt : cnt + 11'd1;

    // Output byte selection and handshakes, purely from state and counter so a stalled byte holds.
    always_comb begin
        out_vld    = 1'b0;
        data_out   = 9'd0;
        in_rdy     = 1'b0;
        frame_done = 1'b0;
        len_err    = 1'b0;
        case (state)
            S_PREAMBLE: begin
                out_vld  = 1'b1;
                data_out = {(cnt == 11'd0), ((cnt == PRE_LAST) ? 8'hD5 : 8'h55)};
            end
            S_HEADER: begin
                out_vld  = 1'b1;
                data_out = {1'b0, hdr_byte};
            end
            S_PAYLOAD: begin
                if (discard) begin
                    in_rdy = 1'b1;
                end else begin
                    in_rdy   = out_rdy;
                    out_vld  = in_vld;
                    data_out = {1'b0, data_in[7:0]};
                end
                // Long enough payload: the last accepted byte closes the frame.
                if (in_acc && in_last && (pay_cnt_nxt >= MIN_PAYLOAD)) begin
                    frame_done = 1'b1;
                    len_err    = discard;
                end
            end
            S_PAD: begin
                out_vld    = 1'b1;
                frame_done = out_rdy && (cnt == PAD_LAST);
            end
            default: begin
            end
        endcase
    end

    // ctrl_rdy may only rise on the first clock edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
        end
    end

    // Frame sequencing; reset drops any frame in flight and returns to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= 11'd0;
            dst_q   <= 48'd0;
            etype_q <= 16'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (ctrl_acc) begin
                        dst_q   <= ctrl[63:16];
                        etype_q <= ctrl[15:0];
                        cnt     <= 11'd0;
                        state   <= S_PREAMBLE;
                    end
                end
                S_PREAMBLE: begin
                    if (out_xfer) begin
                        if (cnt == PRE_LAST) begin
                            cnt   <= 11'd0;
                            state <= S_HEADER;
                        end else begin
                            cnt <= cnt + 11'd1;
                        end
                    end
                end
                S_HEADER: begin
                    if (out_xfer) begin
                        if (cnt == HDR_LAST) begin
                            cnt   <= 11'd0;
                            state <= S_PAYLOAD;
                        end else begin
                            cnt <= cnt + 11'd1;
                        end
                    end
                end
                S_PAYLOAD: begin
                    if (in_acc) begin
                        if (in_last && (pay_cnt_nxt < MIN_PAYLOAD)) begin
                            // Keep the payload count so PAD stops at 46 total.
                            cnt   <= pay_cnt_nxt;
                            state <= S_PAD;
                        end else if (in_last) begin
                            cnt   <= 11'd0;
                            state <= S_IFG;
                        end else begin
                            cnt <= pay_cnt_nxt;
                        end
                    end
                end
                S_PAD: begin
                    if (out_xfer) begin
                        if (cnt == PAD_LAST) begin
                            cnt   <= 11'd0;
                            state <= S_IFG;
                        end else begin
                            cnt <= cnt + 11'd1;
                        end
                    end
                end
                S_IFG: begin
                    // A gap slot only elapses when the link could have taken a byte.
                    if (out_rdy) begin
                        if (cnt == IFG_LAST) begin
                            cnt   <= 11'd0;
                            state <= S_IDLE;
                        end else begin
                            cnt <= cnt + 11'd1;
                        end
                    end
                end
                default: begin
                    cnt   <= 11'd0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eth_encoder.sv
// Self-checking bench for eth_encoder: frame table with random payload and handshakes
// checked against a byte-list model, plus reset, mid-frame reset and back-to-back sequences.
module tb_eth_encoder;

    localparam int          IFG    = 12;
    localparam logic [47:0] MY_MAC = 48'h00183E02523A;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] ctrl;
    logic        ctrl_vld;
    logic        ctrl_rdy;
    logic [8:0]  data_in;
    logic        in_vld;
    logic        in_rdy;
    logic [8:0]  data_out;
    logic        out_vld;
    logic        out_rdy;
    logic        frame_done;
    logic        len_err;

    eth_encoder #(.P_MY_MAC(MY_MAC), .P_IFG_BYTES(IFG)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ctrl       (ctrl),
        .ctrl_vld   (ctrl_vld),
        .ctrl_rdy   (ctrl_rdy),
        .data_in    (data_in),
        .in_vld     (in_vld),
        .in_rdy     (in_rdy),
        .data_out   (data_out),
        .out_vld    (out_vld),
        .out_rdy    (out_rdy),
        .frame_done (frame_done),
        .len_err    (len_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [47:0] dst;
        logic [15:0] et;
        int          len;
        int          ordy_pct;
        int          ivld_pct;
        int          exp_xfers;
        bit          exp_lerr;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Run one frame with random payload bytes and random handshakes, compare with the model.
    task automatic run_frame(input vec_t v, input string nm);
        logic [7:0] pay[$];
        logic [7:0] exp_q[$];
        logic [7:0] got[$];
        int emit, in_idx, cyc, fd_cnt, fd_cyc, last_out_cyc, last_in_cyc;
        int stab_err, inst_err, sof_err, lerr_stray, mism, n, ifg_err;
        bit ok, acc, stall_prev, lerr_seen;
        logic [8:0] prev_dat;

        // Reference: preamble, SFD, header, first 1500 payload bytes, zero pad to 46.
        for (int i = 0; i < v.len; i++) pay.push_back(8'($urandom));
        for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        for (int i = 5; i >= 0; i--) exp_q.push_back(8'(v.dst >> (8 * i)));
        for (int i = 5; i >= 0; i--) exp_q.push_back(8'(MY_MAC >> (8 * i)));
        exp_q.push_back(8'(v.et >> 8));
        exp_q.push_back(8'(v.et));
        emit = (v.len > 1500) ? 1500 : v.len;
        for (int i = 0; i < emit; i++) exp_q.push_back(pay[i]);
        for (int i = emit; i < 46; i++) exp_q.push_back(8'h00);

        @(posedge clk); #1;
        ctrl = {v.dst, v.et};
        ctrl_vld = 1'b1;
        in_vld = 1'b0;
        out_rdy = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (ctrl_rdy) begin
                ok = 1'b1;
                break;
            end
        end
        check({nm, "/ctrl_accept"}, ok, 1);
        if (!ok) begin
            ctrl_vld = 1'b0;
            return;
        end
        @(posedge clk); #1;
        ctrl_vld = 1'b0;

        in_idx = 0; cyc = 0; fd_cnt = 0; fd_cyc = -1; last_out_cyc = -2; last_in_cyc = -2;
        stab_err = 0; inst_err = 0; sof_err = 0; lerr_stray = 0;
        acc = 1'b0; stall_prev = 1'b0; lerr_seen = 1'b0; prev_dat = 9'd0;
        while (1) begin
            out_rdy = ($urandom_range(99) < v.ordy_pct);
            if (in_idx < v.len) begin
                if (!in_vld || acc) in_vld = ($urandom_range(99) < v.ivld_pct);
                data_in = {(in_idx == v.len - 1), pay[in_idx]};
            end else begin
                in_vld = 1'b0;
            end
            @(negedge clk);
            if (stall_prev && (!out_vld || data_out != prev_dat)) stab_err++;
            stall_prev = out_vld && !out_rdy;
            prev_dat = data_out;
            if (out_vld && out_rdy) begin
                if (data_out[8] != (got.size() == 0)) sof_err++;
                got.push_back(data_out[7:0]);
                last_out_cyc = cyc;
            end
            if (in_vld && out_rdy && !in_rdy && in_idx > 0) inst_err++;
            acc = in_vld && in_rdy;
            if (acc) begin
                in_idx++;
                last_in_cyc = cyc;
            end
            if (frame_done) begin
                fd_cnt++;
                fd_cyc = cyc;
                lerr_seen = len_err;
            end else if (len_err) begin
                lerr_stray++;
            end
            cyc++;
            if (fd_cnt > 0 || cyc > 8000) break;
            @(posedge clk); #1;
        end

        // Gap: out_vld low until ctrl_rdy returns, counted with out_rdy held high.
        @(posedge clk); #1;
        in_vld = 1'b0;
        out_rdy = 1'b1;
        n = 0;
        ifg_err = 0;
        while (1) begin
            @(negedge clk);
            n++;
            if (out_vld || frame_done || len_err) ifg_err++;
            if (ctrl_rdy || n > 200) break;
            @(posedge clk); #1;
        end

        mism = 0;
        for (int i = 0; i < exp_q.size(); i++)
            if (i >= got.size() || got[i] != exp_q[i]) mism++;

        check({nm, "/no_timeout"}, (cyc > 8000), 0);
        check({nm, "/xfers"}, got.size(), v.exp_xfers);
        check({nm, "/byte_mismatches"}, mism, 0);
        check({nm, "/sof_flag_errs"}, sof_err, 0);
        check({nm, "/stall_unstable"}, stab_err, 0);
        check({nm, "/in_rdy_not_out_rdy"}, inst_err, 0);
        check({nm, "/bytes_accepted"}, in_idx, v.len);
        check({nm, "/frame_done_cnt"}, fd_cnt, 1);
        check({nm, "/frame_done_cycle"}, fd_cyc, (v.len > 1500) ? last_in_cyc : last_out_cyc);
        check({nm, "/len_err"}, lerr_seen, v.exp_lerr);
        check({nm, "/len_err_stray"}, lerr_stray, 0);
        check({nm, "/ifg_activity"}, ifg_err, 0);
        check({nm, "/done_to_ctrl_rdy"}, n, IFG + 1);
    endtask

    // Reset asserted while the fifth header byte is on the bus.
    task automatic reset_mid_header();
        int n, fd;
        @(posedge clk); #1;
        ctrl = {48'h112233445566, 16'h86DD};
        ctrl_vld = 1'b1;
        out_rdy = 1'b1;
        in_vld = 1'b0;
        n = 0;
        fd = 0;
        for (int k = 0; k < 100 && n < 12; k++) begin
            @(negedge clk);
            if (out_vld && out_rdy) n++;
            if (frame_done) fd++;
            @(posedge clk); #1;
            if (n > 0) ctrl_vld = 1'b0;
        end
        check("mid/xfers_before_reset", n, 12);
        check("mid/hdr_byte5", data_out, 9'h055);
        check("mid/hdr_byte5_vld", out_vld, 1);
        rst_n = 1'b0;
        #1;
        check("mid/out_vld_in_reset", out_vld, 0);
        check("mid/data_out_in_reset", data_out, 0);
        check("mid/ctrl_rdy_in_reset", ctrl_rdy, 0);
        @(negedge clk);
        if (frame_done) fd++;
        check("mid/no_frame_done", fd, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // ctrl_vld held high across two 46-byte frames; measure the gap between them.
    task automatic back_to_back();
        int idx, sof_cnt, fd_seen, gap_low, gap_busy, f2_xfers;
        @(posedge clk); #1;
        ctrl = {48'h0A0B0C0D0E0F, 16'h88B5};
        ctrl_vld = 1'b1;
        out_rdy = 1'b1;
        in_vld = 1'b1;
        idx = 0; sof_cnt = 0; fd_seen = 0; gap_low = 0; gap_busy = 0; f2_xfers = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            data_in = {(idx == 45), 8'(idx + 1)};
            @(negedge clk);
            if (out_vld && out_rdy) begin
                if (data_out[8]) sof_cnt++;
                if (sof_cnt == 2) f2_xfers++;
            end
            if (fd_seen == 1 && sof_cnt == 1 && !out_vld) begin
                gap_low++;
                if (!ctrl_rdy) gap_busy++;
            end
            if (in_vld && in_rdy) idx = (idx == 45) ? 0 : idx + 1;
            if (frame_done) fd_seen++;
            if (fd_seen == 2) break;
            @(posedge clk); #1;
            if (sof_cnt == 2) ctrl_vld = 1'b0;
        end
        in_vld = 1'b0;
        ctrl_vld = 1'b0;
        check("b2b/frames_done", fd_seen, 2);
        check("b2b/ifg_slots", gap_busy, IFG);
        check("b2b/idle_gap_cycles", gap_low, IFG + 1);
        check("b2b/frame2_xfers", f2_xfers, 68);
    endtask

    initial begin
        vecs[0] = '{48'hFFFFFFFFFFFF, 16'h0800,   60, 100, 100,   82, 1'b0};
        vecs[1] = '{48'h020000000001, 16'h0800,   10, 100, 100,   68, 1'b0};
        vecs[2] = '{48'hFFFFFFFFFFFF, 16'h0800,   60,  50, 100,   82, 1'b0};
        vecs[3] = '{48'h001122334455, 16'h0800, 1510, 100, 100, 1522, 1'b1};
        vecs[4] = '{48'h0A0000000001, 16'h88B5,    1, 100, 100,   68, 1'b0};
        vecs[5] = '{48'hDEADBEEF0001, 16'h86DD,   46,  70,  60,   68, 1'b0};
        vecs[6] = '{48'h5A5A5A5A5A5A, 16'h0806,   45, 100, 100,   68, 1'b0};
        vecs[7] = '{48'h123456789ABC, 16'h0800, 1500, 100, 100, 1522, 1'b0};
        vecs[8] = '{48'hCAFEF00D0102, 16'h0800, 1501,  60,  80, 1522, 1'b1};
        vecs[9] = '{48'h0180C2000000, 16'h8100,  100,  50,  50,  122, 1'b0};

        rst_n = 1'b0;
        ctrl = 64'd0;
        ctrl_vld = 1'b0;
        data_in = 9'd0;
        in_vld = 1'b0;
        out_rdy = 1'b0;
        #12;
        check("rst/out_vld", out_vld, 0);
        check("rst/in_rdy", in_rdy, 0);
        check("rst/ctrl_rdy", ctrl_rdy, 0);
        check("rst/frame_done", frame_done, 0);
        check("rst/len_err", len_err, 0);
        check("rst/data_out", data_out, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst/ctrl_rdy_before_edge", ctrl_rdy, 0);
        @(negedge clk);
        check("rst/ctrl_rdy_first_edge", ctrl_rdy, 1);
        check("rst/in_rdy_idle", in_rdy, 0);

        for (int i = 0; i < 10; i++) run_frame(vecs[i], $sformatf("vec%0d", i));

        reset_mid_header();
        run_frame(vecs[0], "after_reset");

        back_to_back();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/eth_encoder.md
ETH_ENCODER -- requirements
Module: eth_encoder

Interface
REQ-001 SHALL have parameter P_MY_MAC, default 48'h00183E02523A, source MAC inserted in every frame.
REQ-002 SHALL have parameter P_IFG_BYTES, default 12, inter-frame gap in byte slots.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 ctrl  input  64  frame header request: ctrl[63:16] destination MAC, ctrl[15:0] EtherType.
REQ-006 ctrl_vld  input  1  ctrl valid.
REQ-007 ctrl_rdy  output  1  high only in IDLE; request accepted when ctrl_vld & ctrl_rdy.
REQ-008 data_in  input  9  payload: data_in[7:0] byte, data_in[8] last-byte flag.
REQ-009 in_vld  input  1  data_in valid.
REQ-010 in_rdy  output  1  payload byte accepted when in_vld & in_rdy.
REQ-011 data_out  output  9  data_out[7:0] byte, data_out[8] start-of-frame (first preamble byte only).
REQ-012 out_vld  output  1  data_out valid.
REQ-013 out_rdy  input  1  downstream byte accept; transfer when out_vld & out_rdy.
REQ-014 frame_done  output  1  one-cycle pulse on transfer of final frame byte.
REQ-015 len_err  output  1  one-cycle pulse with frame_done when payload exceeded 1500 bytes.

Function
REQ-016 States SHALL be IDLE, PREAMBLE, HEADER, PAYLOAD, PAD, IFG.
REQ-017 On ctrl accept, dst MAC and EtherType SHALL be registered; state -> PREAMBLE; out_vld high next cycle.
REQ-018 PREAMBLE SHALL emit 7 bytes 0x55 then 1 byte 0xD5 (SFD), one per transfer.
REQ-019 HEADER SHALL emit 14 bytes: dst MAC, P_MY_MAC, EtherType, each most-significant byte first.
REQ-020 PAYLOAD: in_rdy = out_rdy, out_vld = in_vld, data_out[7:0] = data_in[7:0] combinationally; no stall bubbles.
REQ-021 An 11-bit payload counter SHALL count accepted bytes, saturating at 2047.
REQ-022 Bytes beyond 1500 SHALL be accepted (in_rdy high) but not emitted (out_vld low); len_err pulses at frame end.
REQ-023 On accepting last byte: count < 46 -> PAD; else -> IFG with frame_done on that transfer.
REQ-024 PAD SHALL emit 0x00 until payload+pad = 46 bytes, frame_done on final pad transfer, then -> IFG.
REQ-025 IFG SHALL hold out_vld low for P_IFG_BYTES cycles with out_rdy high, then -> IDLE.
REQ-026 in_rdy SHALL be low outside PAYLOAD; ctrl_rdy low outside IDLE.
REQ-027 While out_vld & ~out_rdy, data_out SHALL remain stable (except PAYLOAD pass-through, stable by upstream rule).
REQ-028 Last flag on payload byte 1 (single-byte payload) SHALL yield 45 pad bytes.
REQ-029 Frame-done-to-next-ctrl_rdy latency SHALL be P_IFG_BYTES out_rdy cycles +1.
REQ-030 No FCS is generated; data_out excludes FCS.

Reset
REQ-031 rst_n low SHALL asynchronously force IDLE, counters 0, out_vld 0, in_rdy 0, ctrl_rdy 0, frame_done 0, len_err 0, data_out 0.
REQ-032 ctrl_rdy SHALL rise the first clock after rst_n deasserts.
REQ-033 Reset mid-frame SHALL abort the frame with no frame_done; no partial frame resumes.

Verification
REQ-034 ctrl={FFFFFFFFFFFF,0800}, 60-byte payload, out_rdy=1 -> 55x7,D5,FF x6,00 18 3E 02 52 3A,08 00, 60 bytes, frame_done; total 82 transfers.
REQ-035 10-byte payload -> 10 bytes then 36 0x00, frame_done on final pad byte, 68 transfers.
REQ-036 out_rdy toggled randomly 50% -> byte sequence identical to REQ-034, data_out stable during stalls.
REQ-037 1510-byte payload -> 1500 emitted, in_rdy high for all 1510, len_err and frame_done together.
REQ-038 rst_n low during HEADER byte 5 -> out_vld 0 immediately, no frame_done, next ctrl produces full correct frame.
REQ-039 Back-to-back ctrl_vld held high -> exactly 12 out_rdy cycles with out_vld low between frames.
